// File: rtl/l2_cache_control_if.sv
// ----------------------------------------------------------------------------
// l2_cache_control_if
// Purpose : groups the L1 handshake, cache array status/strobes, LRU array
//           and pmem handshake signals of the L2 cache controller.
// Modports:
//   master - controller view (drives responses, strobes, pmem requests)
//   slave  - datapath / L1 / pmem view (drives requests and status)
// Signals :
//   l2_read, l2_write, l2_resp          L1 request / completion pulse
//   hit_vec[3:0], dirty_vec[3:0]        per-way status for current index
//   lru_way[1:0], lru_write, lru_in     LRU array read way / update
//   way_sel, data_load, data_src,       array strobes and way select
//   tag_load, valid_set, dirty_set, dirty_clr
//   pmem_addr_sel, pmem_read, pmem_write, pmem_resp, pmem_err
// ----------------------------------------------------------------------------
interface l2_cache_control_if;
   logic       l2_read;
   logic       l2_write;
   logic       l2_resp;
   logic [3:0] hit_vec;
   logic [3:0] dirty_vec;
   logic [1:0] lru_way;
   logic       lru_write;
   logic [1:0] lru_in;
   logic [1:0] way_sel;
   logic       data_load;
   logic       data_src;
   logic       tag_load;
   logic       valid_set;
   logic       dirty_set;
   logic       dirty_clr;
   logic       pmem_addr_sel;
   logic       pmem_read;
   logic       pmem_write;
   logic       pmem_resp;
   logic       pmem_err;

   modport master (
      input  l2_read, l2_write, hit_vec, dirty_vec, lru_way, pmem_resp,
      output l2_resp, lru_write, lru_in, way_sel, data_load, data_src,
             tag_load, valid_set, dirty_set, dirty_clr, pmem_addr_sel,
             pmem_read, pmem_write, pmem_err
   );

   modport slave (
      output l2_read, l2_write, hit_vec, dirty_vec, lru_way, pmem_resp,
      input  l2_resp, lru_write, lru_in, way_sel, data_load, data_src,
             tag_load, valid_set, dirty_set, dirty_clr, pmem_addr_sel,
             pmem_read, pmem_write, pmem_err
   );
endinterface

// File: rtl/l2_cache_control.sv
// ----------------------------------------------------------------------------
// l2_cache_control
// Purpose : control FSM of the 4-way, 16-set L2 cache. Resolves hit/miss,
//           updates the LRU array, picks the LRU victim, and sequences
//           dirty-victim writeback and line fill on the pmem side.
// Ports   :
//   clk      - single clock, rising edge
//   reset_n  - synchronous active-low reset
//   bus      - l2_cache_control_if.master (L1, arrays, LRU, pmem)
//   perf_hit/perf_miss/perf_wb - 16-bit saturating event counters
//              (present only when L2_PERF_CNT_EN is defined)
// Parameter: TIMEOUT_CYCLES - pmem wait budget before pmem_err is raised
// Config   : `define L2_PERF_CNT_EN to add the performance counters.
// Note     : strobes are combinational from state and array status so a
//            hit completes in the COMPARE cycle; pmem_err is registered.
// ----------------------------------------------------------------------------
module l2_cache_control #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   l2_cache_control_if.master    bus
`ifdef L2_PERF_CNT_EN
   ,
   output logic [15:0]           perf_hit,
   output logic [15:0]           perf_miss,
   output logic [15:0]           perf_wb
`endif
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_COMPARE   = 2'd1,
      S_WRITEBACK = 2'd2,
      S_ALLOCATE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [1:0]       r_victim;
   logic [TMR_W-1:0] r_timer;
   logic             r_pmem_err;

   logic             w_req;
   logic             w_hit;
   logic [1:0]       w_hit_way;
   logic             w_cmp_miss;
   logic             w_timeout;

   logic             w_l2_resp;
   logic             w_lru_write;
   logic [1:0]       w_lru_in;
   logic [1:0]       w_way_sel;
   logic             w_data_load;
   logic             w_data_src;
   logic             w_tag_load;
   logic             w_valid_set;
   logic             w_dirty_set;
   logic             w_dirty_clr;
   logic             w_pmem_addr_sel;
   logic             w_pmem_read;
   logic             w_pmem_write;

   assign w_req = bus.l2_read | bus.l2_write;
   assign w_hit = |bus.hit_vec;

   // Lowest-index way wins on a multi-hot hit vector.
   always_comb begin
      w_hit_way = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (bus.hit_vec[i]) w_hit_way = 2'(i);
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      w_state_next    = r_state;
      w_cmp_miss      = 1'b0;
      w_timeout       = 1'b0;
      w_l2_resp       = 1'b0;
      w_lru_write     = 1'b0;
      w_lru_in        = 2'd0;
      w_way_sel       = 2'd0;
      w_data_load     = 1'b0;
      w_data_src      = 1'b0;
      w_tag_load      = 1'b0;
      w_valid_set     = 1'b0;
      w_dirty_set     = 1'b0;
      w_dirty_clr     = 1'b0;
      w_pmem_addr_sel = 1'b0;
      w_pmem_read     = 1'b0;
      w_pmem_write    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_req) w_state_next = S_COMPARE;
         end

         S_COMPARE: begin
            if (!w_req) begin
               w_state_next = S_IDLE;
            end else if (w_hit) begin
               w_l2_resp    = 1'b1;
               w_lru_write  = 1'b1;
               w_lru_in     = w_hit_way;
               w_way_sel    = w_hit_way;
               if (bus.l2_write) begin
                  w_data_load = 1'b1;
                  w_dirty_set = 1'b1;
               end
               w_state_next = S_IDLE;
            end else begin
               w_cmp_miss   = 1'b1;
               w_state_next = bus.dirty_vec[bus.lru_way] ? S_WRITEBACK : S_ALLOCATE;
            end
         end

         S_WRITEBACK: begin
            w_pmem_write    = 1'b1;
            w_pmem_addr_sel = 1'b1;
            w_way_sel       = r_victim;
            if (bus.pmem_resp) begin
               w_state_next = S_ALLOCATE;
            end else if (r_timer == TMR_LAST) begin
               w_timeout    = 1'b1;
               w_state_next = S_IDLE;
            end
         end

         S_ALLOCATE: begin
            w_pmem_read = 1'b1;
            w_way_sel   = r_victim;
            if (bus.pmem_resp) begin
               w_data_load  = 1'b1;
               w_data_src   = 1'b1;
               w_tag_load   = 1'b1;
               w_valid_set  = 1'b1;
               w_dirty_clr  = 1'b1;
               w_state_next = S_COMPARE;
            end else if (r_timer == TMR_LAST) begin
               w_timeout    = 1'b1;
               w_state_next = S_IDLE;
            end
         end

         default: w_state_next = S_IDLE;
      endcase
   end

   // State, victim, pmem timer and sticky error.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_victim   <= 2'd0;
         r_timer    <= '0;
         r_pmem_err <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_cmp_miss) r_victim <= bus.lru_way;
         // Any state change restarts the timer, covering entry to both pmem states.
         if (w_state_next != r_state) begin
            r_timer <= '0;
         end else if (r_state == S_WRITEBACK || r_state == S_ALLOCATE) begin
            r_timer <= r_timer + TMR_W'(1);
         end
         if (w_timeout) r_pmem_err <= 1'b1;
      end
   end

   assign bus.l2_resp       = w_l2_resp;
   assign bus.lru_write     = w_lru_write;
   assign bus.lru_in        = w_lru_in;
   assign bus.way_sel       = w_way_sel;
   assign bus.data_load     = w_data_load;
   assign bus.data_src      = w_data_src;
   assign bus.tag_load      = w_tag_load;
   assign bus.valid_set     = w_valid_set;
   assign bus.dirty_set     = w_dirty_set;
   assign bus.dirty_clr     = w_dirty_clr;
   assign bus.pmem_addr_sel = w_pmem_addr_sel;
   assign bus.pmem_read     = w_pmem_read;
   assign bus.pmem_write    = w_pmem_write;
   assign bus.pmem_err      = r_pmem_err;

`ifdef L2_PERF_CNT_EN
   logic       w_ev_hit;
   logic       w_ev_wb;
   logic [15:0] r_perf_hit;
   logic [15:0] r_perf_miss;
   logic [15:0] r_perf_wb;

   assign w_ev_hit = (r_state == S_COMPARE) && w_req && w_hit;
   assign w_ev_wb  = (r_state == S_WRITEBACK) && bus.pmem_resp;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_perf_hit  <= 16'd0;
         r_perf_miss <= 16'd0;
         r_perf_wb   <= 16'd0;
      end else begin
         if (w_ev_hit   && r_perf_hit  != 16'hFFFF) r_perf_hit  <= r_perf_hit  + 16'd1;
         if (w_cmp_miss && r_perf_miss != 16'hFFFF) r_perf_miss <= r_perf_miss + 16'd1;
         if (w_ev_wb    && r_perf_wb   != 16'hFFFF) r_perf_wb   <= r_perf_wb   + 16'd1;
      end
   end

   assign perf_hit  = r_perf_hit;
   assign perf_miss = r_perf_miss;
   assign perf_wb   = r_perf_wb;
`endif

endmodule
